// File: rtl/urv_mem_arb.sv
// +----------------------------------------------------------------------------+
// | Module  : urv_mem_arb                                                      |
// | Brief   : Round-robin 2:1 mem_if arbiter with in-order response routing.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package urv_mem_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        resp_last;
  } mem_resp_t;
endpackage

module urv_mem_arb
  import urv_mem_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m0_req_valid,
  output logic                          m0_req_ready,
  input  mem_req_t                      m0_req,
  output logic                          m0_resp_valid,
  input  logic                          m0_resp_ready,
  output mem_resp_t                     m0_resp,
  input  logic                          m1_req_valid,
  output logic                          m1_req_ready,
  input  mem_req_t                      m1_req,
  output logic                          m1_resp_valid,
  input  logic                          m1_resp_ready,
  output mem_resp_t                     m1_resp,
  output logic                          s_req_valid,
  input  logic                          s_req_ready,
  output mem_req_t                      s_req,
  input  logic                          s_resp_valid,
  output logic                          s_resp_ready,
  input  mem_resp_t                     s_resp,
  output logic [$clog2(OUTSTANDING):0]  outstanding,
  output logic                          err_orphan
);

  localparam int c_PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int c_CNT_W = $clog2(OUTSTANDING) + 1;
  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(OUTSTANDING);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(OUTSTANDING - 1);

  logic               r_route [OUTSTANDING];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_last_grant;
  logic               r_err_orphan;

  logic w_full;
  logic w_empty;
  logic w_grant1;
  logic w_head;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  // On a tie the requester that did not win last time goes next.
  assign w_grant1 = m1_req_valid & (~m0_req_valid | ~r_last_grant);

  assign s_req_valid  = (m0_req_valid | m1_req_valid) & ~w_full;
  assign s_req        = w_grant1 ? m1_req : m0_req;
  assign m0_req_ready = m0_req_valid & ~w_grant1 & s_req_ready & ~w_full;
  assign m1_req_ready = w_grant1 & s_req_ready & ~w_full;

  assign w_head        = r_route[r_rd_ptr];
  assign m0_resp_valid = s_resp_valid & ~w_empty & ~w_head;
  assign m1_resp_valid = s_resp_valid & ~w_empty & w_head;
  // With nothing in flight the target response is drained as an orphan.
  assign s_resp_ready  = w_empty ? 1'b1 : (w_head ? m1_resp_ready : m0_resp_ready);
  assign m0_resp       = s_resp;
  assign m1_resp       = s_resp;

  assign w_push = s_req_valid & s_req_ready;
  assign w_pop  = s_resp_valid & s_resp_ready & s_resp.resp_last & ~w_empty;

  assign outstanding = r_count;
  assign err_orphan  = r_err_orphan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
      r_err_orphan <= 1'b0;
      for (int i = 0; i < OUTSTANDING; i++) r_route[i] <= 1'b0;
    end else begin
      if (w_push) begin
        r_route[r_wr_ptr] <= w_grant1;
        r_wr_ptr          <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
        r_last_grant      <= w_grant1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (s_resp_valid & w_empty) r_err_orphan <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_urv_mem_arb.sv
// Randomized bench for urv_mem_arb: a queue-based routing model plus a
// behavioural target with multi-beat responses drives every check.
`default_nettype none

module tb_urv_mem_arb;
  import urv_mem_pkg::*;

  localparam int OUTSTANDING = 2;
  localparam int c_CYCLES    = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req_valid = 1'b0, m0_req_ready, m0_resp_valid, m0_resp_ready = 1'b0;
  logic m1_req_valid = 1'b0, m1_req_ready, m1_resp_valid, m1_resp_ready = 1'b0;
  logic s_req_valid, s_req_ready = 1'b0, s_resp_valid = 1'b0, s_resp_ready;
  mem_req_t  m0_req = '0, m1_req = '0, s_req;
  mem_resp_t m0_resp, m1_resp, s_resp = '0;
  logic [$clog2(OUTSTANDING):0] outstanding;
  logic err_orphan;

  urv_mem_arb #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req(m0_req),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req(m1_req),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req(s_req),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp(s_resp),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference state: requester IDs in issue order, last winner, sticky error.
  int route_q[$];
  int last_grant;
  bit err_m;
  // Target model: beats still to deliver for each accepted request, in order.
  int beats_q[$];

  task automatic model_reset();
    route_q.delete();
    beats_q.delete();
    last_grant = 1;
    err_m      = 1'b0;
  endtask

  task automatic drive_random(input bit allow_orphan);
    m0_req_valid  = ($urandom_range(99) < 60);
    m1_req_valid  = ($urandom_range(99) < 60);
    m0_req        = '{addr: $urandom, wdata: $urandom, be: 4'($urandom), we: 1'($urandom)};
    m1_req        = '{addr: $urandom, wdata: $urandom, be: 4'($urandom), we: 1'($urandom)};
    s_req_ready   = ($urandom_range(99) < 75);
    m0_resp_ready = ($urandom_range(99) < 70);
    m1_resp_ready = ($urandom_range(99) < 70);
    if (beats_q.size() > 0) begin
      s_resp_valid = ($urandom_range(99) < 70);
      s_resp       = '{rdata: $urandom, resp_last: (beats_q[0] == 1)};
    end else begin
      s_resp_valid = allow_orphan && ($urandom_range(99) < 4);
      s_resp       = '{rdata: $urandom, resp_last: 1'($urandom)};
    end
  endtask

  // Compare every output with the model, then advance the model one cycle.
  task automatic check_and_step();
    bit full, empty, any, push, pop, e_srr;
    int g, head;
    full  = (route_q.size() == OUTSTANDING);
    empty = (route_q.size() == 0);
    any   = m0_req_valid || m1_req_valid;
    if (m0_req_valid && m1_req_valid) g = 1 - last_grant;
    else if (m1_req_valid)            g = 1;
    else                              g = 0;
    head  = empty ? 0 : route_q[0];
    e_srr = empty ? 1'b1 : (head == 1 ? m1_resp_ready : m0_resp_ready);
    push  = any && !full && s_req_ready;
    pop   = s_resp_valid && e_srr && s_resp.resp_last && !empty;

    check("s_req_valid", 128'(s_req_valid), 128'(any && !full));
    check("m0_req_ready", 128'(m0_req_ready), 128'(m0_req_valid && g == 0 && s_req_ready && !full));
    check("m1_req_ready", 128'(m1_req_ready), 128'(m1_req_valid && g == 1 && s_req_ready && !full));
    if (any) check("s_req", 128'(s_req), 128'(g == 1 ? m1_req : m0_req));
    check("m0_resp_valid", 128'(m0_resp_valid), 128'(s_resp_valid && !empty && head == 0));
    check("m1_resp_valid", 128'(m1_resp_valid), 128'(s_resp_valid && !empty && head == 1));
    check("s_resp_ready", 128'(s_resp_ready), 128'(e_srr));
    check("m0_resp", 128'(m0_resp), 128'(s_resp));
    check("m1_resp", 128'(m1_resp), 128'(s_resp));
    check("outstanding", 128'(outstanding), 128'(route_q.size()));
    check("err_orphan", 128'(err_orphan), 128'(err_m));

    if (s_resp_valid && empty) err_m = 1'b1;
    if (s_resp_valid && e_srr && beats_q.size() > 0) begin
      if (beats_q[0] == 1) void'(beats_q.pop_front());
      else beats_q[0] = beats_q[0] - 1;
    end
    if (pop) void'(route_q.pop_front());
    if (push) begin
      route_q.push_back(g);
      beats_q.push_back($urandom_range(1, 2));
      last_grant = g;
    end
  endtask

  task automatic idle_inputs();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_req_ready = 1'b0;
    s_resp_valid = 1'b0; m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outstanding", 128'(outstanding), 128'(0));
    check("reset_err_orphan", 128'(err_orphan), 128'(0));
    check("reset_s_resp_ready", 128'(s_resp_ready), 128'(1));
    check("reset_s_req_valid", 128'(s_req_valid), 128'(0));

    // Orphan pulse with nothing in flight; the flag must stay set afterwards.
    @(posedge clk); #1;
    s_resp_valid = 1'b1; s_resp = '{rdata: 32'hdead_beef, resp_last: 1'b1};
    @(negedge clk); check_and_step();
    @(posedge clk); #1 idle_inputs();
    @(negedge clk); check_and_step();
    check("orphan_sticky", 128'(err_orphan), 128'(1));

    for (int cyc = 0; cyc < c_CYCLES; cyc++) begin
      @(posedge clk); #1;
      if (cyc % 400 == 399) begin
        // Mid-operation reset; outputs this cycle still reflect the old state.
        rst = 1'b1;
        drive_random(1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle_inputs();
        m0_req_valid = 1'b1; m1_req_valid = 1'b1; s_req_ready = 1'b1;
        @(negedge clk);
        check("post_rst_outstanding", 128'(outstanding), 128'(0));
        check("post_rst_err", 128'(err_orphan), 128'(0));
        check("post_rst_m0_first", 128'(m0_req_ready), 128'(1));
        check_and_step();
      end else begin
        drive_random(1'b1);
        @(negedge clk);
        check_and_step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
